// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the round-robin APB master arbiter.
// APB_ADDR_W/APB_DATA_W size the latched request and bound ADDR_W/DATA_W.
package apb_arb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: first valid request at or above ptr_i, wrapping to bit 0.
// Purely combinational and protocol-agnostic.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic                       en_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] upper;
  logic [IDX_W-1:0]   up_idx;
  logic [IDX_W-1:0]   low_idx;
  logic               any_up;

  // NOTE: every variable written in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    upper   = '0;
    up_idx  = '0;
    low_idx = '0;
    any_up  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = req_valid_i[i] && (i >= int'(ptr_i));
    end
    // Scanning downwards lets the lowest set bit win in each half.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper[i]) begin
        up_idx = IDX_W'(i);
        any_up = 1'b1;
      end
      if (req_valid_i[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  assign idx_o = any_up ? up_idx : low_idx;
  assign gnt_o = (en_i && |req_valid_i) ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters (round-robin, IDLE/SETUP/ACCESS).
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without PREADY.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_W-1:0]         PRDATA
);

  localparam int IDX_W = $clog2(NUM_REQ);

  apb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  apb_req_t            req_q, req_d, sel_req;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]  win_gnt;
  logic [IDX_W-1:0]    win_idx;
  logic                arb_en;
  logic                done;
  logic                timeout;

  assign done   = (state_q == ACCESS) && PREADY;
  // Gated by PRESET so no grant escapes while the block is held in reset.
  assign arb_en = PRESET && ((state_q == IDLE) || done);

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid_i (req_valid),
    .en_i        (arb_en),
    .ptr_i       (ptr_q),
    .gnt_o       (win_gnt),
    .idx_o       (win_idx)
  );

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_gnt[i]) begin
        sel_req.write = req_write[i];
        sel_req.addr  = APB_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
        sel_req.wdata = req_write[i] ? APB_DATA_W'(req_wdata[i*DATA_W +: DATA_W]) : '0;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed ACCESS cycles without PREADY; the TIMEOUT_CYC-th one aborts.
  assign timeout = (state_q == ACCESS) && !PREADY && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !PREADY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!PRESET) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    req_d       = req_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE:    if (|win_gnt) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (done)         state_d = (|win_gnt) ? SETUP : IDLE;
        else if (timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done || timeout) begin
      rsp_valid_d = NUM_REQ'(1) << owner_q;
      rsp_rdata_d = (done && !req_q.write) ? PRDATA : '0;
      rsp_err_d   = timeout ? 1'b1 : PSLVERR;
    end

    if (|win_gnt) begin
      ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      owner_d = win_idx;
      req_d   = sel_req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!PRESET) begin
      // NOTE: the datapath registers are reset too, because the bus outputs must read zero after reset.
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      req_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_gnt   = win_gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign busy      = PSEL;
  assign PADDR     = ADDR_W'(req_q.addr);
  assign PWRITE    = req_q.write;
  assign PWDATA    = DATA_W'(req_q.wdata);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: vector table of single transfers plus
// round-robin, mid-transfer reset and (with APB_ARB_TIMEOUT_EN) timeout sequences.
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk;
  logic             PRESET;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_gnt;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             busy;
  logic [AW-1:0]    PADDR;
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [DW-1:0]    PWDATA;
  logic             PREADY;
  logic             PSLVERR;
  logic [DW-1:0]    PRDATA;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_pwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"},      PSEL,      0);
    check({tag, "_penable"},   PENABLE,   0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_paddr"},     PADDR,     0);
    check({tag, "_pwrite"},    PWRITE,    0);
    check({tag, "_pwdata"},    PWDATA,    0);
    check({tag, "_gnt"},       req_gnt,   0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"},   rsp_err,   0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", n);
    @(negedge clk);
    req_valid = '0; req_valid[v.req] = 1'b1;
    req_write = '0; req_write[v.req] = v.wr;
    req_addr  = '0; req_addr[v.req*AW +: AW]  = v.addr;
    req_wdata = '0; req_wdata[v.req*DW +: DW] = v.wdata;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    #1;
    check({tag, "_gnt"},       req_gnt, v.exp_gnt);
    check({tag, "_idle_psel"}, PSEL,    0);
    @(negedge clk);
    req_valid = '0;
    #1;
    check({tag, "_setup_psel"},    PSEL,    1);
    check({tag, "_setup_penable"}, PENABLE, 0);
    check({tag, "_setup_busy"},    busy,    1);
    check({tag, "_paddr"},         PADDR,   v.addr);
    check({tag, "_pwrite"},        PWRITE,  v.wr);
    check({tag, "_pwdata"},        PWDATA,  v.exp_pwdata);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge clk);
      PREADY  = (k == v.waits);
      PSLVERR = v.slverr;
      PRDATA  = v.prdata;
      #1;
      check({tag, "_acc_psel"},    PSEL,      1);
      check({tag, "_acc_penable"}, PENABLE,   1);
      check({tag, "_acc_paddr"},   PADDR,     v.addr);
      check({tag, "_acc_pwdata"},  PWDATA,    v.exp_pwdata);
      check({tag, "_acc_norsp"},   rsp_valid, 0);
    end
    @(negedge clk);
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hBAD0_BAD0;
    #1;
    check({tag, "_rsp_valid"}, rsp_valid, v.exp_gnt);
    check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, "_rsp_err"},   rsp_err,   v.exp_err);
    check({tag, "_end_psel"},  PSEL,      0);
    @(negedge clk);
    #1;
    check({tag, "_rsp_pulse"}, rsp_valid, 0);
    check({tag, "_rsp_hold"},  rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    int exp_own[4];
    exp_own = '{0, 1, 0, 1};

    vecs[0] = '{req: 0, wr: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, waits: 0,
                prdata: 32'hFFFF_FFFF, slverr: 1'b0, exp_gnt: 2'b01,
                exp_pwdata: 32'hDEAD_BEEF, exp_rdata: 32'h0, exp_err: 1'b0};
    vecs[1] = '{req: 1, wr: 1'b0, addr: 32'h0000_0020, wdata: 32'hAAAA_5555, waits: 3,
                prdata: 32'h1234_5678, slverr: 1'b0, exp_gnt: 2'b10,
                exp_pwdata: 32'h0, exp_rdata: 32'h1234_5678, exp_err: 1'b0};
    vecs[2] = '{req: 0, wr: 1'b0, addr: 32'h0000_0030, wdata: 32'h1111_2222, waits: 0,
                prdata: 32'hCAFE_0001, slverr: 1'b1, exp_gnt: 2'b01,
                exp_pwdata: 32'h0, exp_rdata: 32'hCAFE_0001, exp_err: 1'b1};
    vecs[3] = '{req: 1, wr: 1'b1, addr: 32'h0000_0044, wdata: 32'h0BAD_F00D, waits: 1,
                prdata: 32'h0000_5555, slverr: 1'b0, exp_gnt: 2'b10,
                exp_pwdata: 32'h0BAD_F00D, exp_rdata: 32'h0, exp_err: 1'b0};

    PRESET = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    PRESET = 1'b1;

    for (int n = 0; n < 4; n++) run_vec(n, vecs[n]);

    // Round-robin, back-to-back: pointer is 0 here, both requesters stay valid.
    @(negedge clk);
    req_valid = 2'b11; req_write = 2'b00;
    req_addr  = {32'h0000_0104, 32'h0000_0100};
    PREADY = 1'b1; PRDATA = 32'h0000_0F00;
    #1;
    check("rr_gnt_first", req_gnt, 2'b01);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      #1;
      check($sformatf("rr%0d_setup_psel", t),    PSEL,    1);
      check($sformatf("rr%0d_setup_penable", t), PENABLE, 0);
      check($sformatf("rr%0d_paddr", t), PADDR, (exp_own[t] == 1) ? 32'h0000_0104 : 32'h0000_0100);
      if (t > 0) check($sformatf("rr%0d_rsp_valid", t), rsp_valid, 64'(1) << exp_own[t-1]);
      @(negedge clk);
      PRDATA = 32'h0000_0F00 + 32'(t);
      if (t == 3) req_valid = '0;
      #1;
      check($sformatf("rr%0d_acc_penable", t), PENABLE, 1);
      check($sformatf("rr%0d_gnt", t), req_gnt, (t < 3) ? (64'(1) << exp_own[t+1]) : 64'(0));
    end
    @(negedge clk);
    PREADY = 1'b0;
    #1;
    check("rr_last_rsp_valid", rsp_valid, 2'b10);
    check("rr_last_rsp_rdata", rsp_rdata, 32'h0000_0F03);
    check("rr_end_psel",       PSEL,      0);

`ifdef APB_ARB_TIMEOUT_EN
    @(negedge clk);
    req_valid = 2'b10; req_write = 2'b00;
    req_addr  = {32'h0000_0050, 32'h0};
    PREADY = 1'b0; PRDATA = 32'h7777_7777;
    #1;
    check("to_gnt", req_gnt, 2'b10);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("to_setup_psel", PSEL, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("to_acc%0d_penable", k), PENABLE,   1);
      check($sformatf("to_acc%0d_norsp", k),   rsp_valid, 0);
    end
    @(negedge clk);
    #1;
    check("to_rsp_valid", rsp_valid, 2'b10);
    check("to_rsp_err",   rsp_err,   1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel_low",  PSEL,      0);
`endif

    // Reset mid-ACCESS; the grant to req0 moves the pointer to 1 beforehand.
    @(negedge clk);
    req_valid = 2'b01; req_write = 2'b01;
    req_addr  = {32'h0000_0070, 32'h0000_0060};
    req_wdata = {32'h0000_0088, 32'h0000_0077};
    PREADY = 1'b0;
    #1;
    check("rst_pre_gnt", req_gnt, 2'b01);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pre_penable", PENABLE, 1);
    @(negedge clk);
    PRESET = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    PRESET = 1'b1;
    #1;
    check("rst_tie_gnt",  req_gnt,   2'b01);
    check("rst_no_rsp",   rsp_valid, 0);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rst_setup_paddr", PADDR, 32'h0000_0060);
    check("rst_no_rsp2",     rsp_valid, 0);
    @(negedge clk);
    PREADY = 1'b1;
    #1;
    check("rst_acc_penable", PENABLE, 1);
    @(negedge clk);
    PREADY = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 2'b01);
    check("rst_rsp_err",   rsp_err,   0);
    check("rst_end_psel",  PSEL,      0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ local requesters using round-robin arbitration.
- Sequences every transfer through the APB IDLE, SETUP and ACCESS phases and waits on PREADY.
- Returns PRDATA and PSLVERR to the requester that was granted.
- Sits between the subsystem's internal masters and the APB slave bus, driving the signals the testbench interface drives.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- TIMEOUT_CYC, 16, ACCESS-phase wait limit; used only with APB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- PRESET  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until granted.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_gnt  out  NUM_REQ  one-hot, one-cycle grant; request fields are sampled in this cycle.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_W  read data; valid while any rsp_valid bit is high.
- rsp_err  out  1  PSLVERR (or timeout) for the completing transfer.
- busy  out  1  high in SETUP and ACCESS.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.
- PRDATA  in  DATA_W  slave read data.

Behaviour:
- Reset (PRESET=0 at a clk edge):
  - All outputs go to 0.
  - FSM goes to IDLE; round-robin pointer goes to 0; timeout counter goes to 0.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Arbitration:
  - Evaluated in IDLE, and in ACCESS in the cycle where PREADY=1.
  - Winner is the first req_valid bit at or above the pointer, wrapping modulo NUM_REQ.
  - On a grant to i: req_gnt[i]=1 for that cycle, pointer becomes (i+1) mod NUM_REQ, and the request is latched into PADDR, PWRITE and PWDATA.
  - PWDATA is forced to 0 for reads.
  - If no request is valid, the pointer is unchanged.
- Transitions:
  - IDLE to SETUP on a grant; otherwise stay in IDLE.
  - SETUP to ACCESS unconditionally after 1 cycle.
  - ACCESS with PREADY=0: stay; PADDR, PWRITE and PWDATA are held stable.
  - ACCESS with PREADY=1:
    - rsp_valid[i] pulses in the next cycle, with rsp_rdata = PRDATA (0 on writes) and rsp_err = PSLVERR, both registered.
    - If a new grant occurs in the same cycle, go to SETUP (back-to-back, no idle cycle).
    - Otherwise go to IDLE.
- Latency: minimum 2 APB cycles per transfer; rsp_valid arrives 1 cycle after the PREADY cycle.
- Simultaneous events:
  - The current owner may re-request during its own completion cycle.
  - It still loses to any other valid requester, because the pointer has already moved past it.
- A requester dropping req_valid before its grant is legal; its request is simply not served.
- rsp_rdata and rsp_err hold their last value while no rsp_valid bit is high.
- Reset mid-transfer:
  - The transfer is abandoned; PSEL and PENABLE are low after the reset edge.
  - No rsp_valid is issued for the abandoned transfer.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in ACCESS while PREADY=0.
  - After TIMEOUT_CYC consecutive ACCESS cycles without PREADY, the transfer is terminated.
  - On termination: rsp_valid[i] pulses, rsp_err=1, rsp_rdata=0, and the FSM goes to IDLE (no back-to-back grant in that cycle).
  - The counter clears on entering SETUP.
- Without the macro: ACCESS waits indefinitely for PREADY, and no counter logic exists.

Decomposition:
- Package apb_arb_pkg:
  - Typedef apb_state_e {IDLE, SETUP, ACCESS}.
  - Struct apb_req_t {write, addr, wdata}.
  - Constants APB_ADDR_W=32 and APB_DATA_W=32.
- Sub-module apb_rr_arbiter (parameter NUM_REQ):
  - Inputs: req_valid, an enable, and the pointer register.
  - Outputs: one-hot grant and the encoded index.
  - Contains no APB knowledge.

Test Plan:
- Single write: req0 write to 0x0000_0010 with data 0xDEAD_BEEF, PREADY=1 at ACCESS.
  - Expect PSEL high for 2 cycles, PENABLE only in the second.
  - Expect rsp_valid[0] one cycle later with rsp_err=0.
- Read with wait states: req1 read from 0x20, PREADY low for 3 ACCESS cycles, then PRDATA=0x1234_5678.
  - PADDR must stay stable throughout.
  - Expect rsp_rdata=0x1234_5678 and rsp_valid[1].
- Round-robin: req0 and req1 held valid continuously for 4 transfers.
  - Expect grant order 0,1,0,1.
  - Expect no IDLE cycle between transfers (PSEL stays high).
- Slave error: PSLVERR=1 with PREADY on a req0 read.
  - Expect rsp_err=1 and the FSM back in IDLE.
- Reset mid-ACCESS: assert PRESET=0 with PREADY=0.
  - Next cycle: all outputs 0 and no rsp_valid.
  - After release: the pointer is 0 and req0 wins a tie.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): hold PREADY=0.
  - Expect rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles.
  - Expect PSEL low the next cycle.
